// File: rtl/accum_pkg.sv
// Shared types and helpers for the N-sample block accumulator: FSM states,
// result/counter width helpers and the sample extension function.
package accum_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Widest sample/sum the extension helper can handle.
  localparam int EXT_MAX_W = 64;

  function automatic int sum_width(input int data_w, input int n_samples);
    return data_w + $clog2(n_samples);
  endfunction

  function automatic int cnt_width(input int n_samples);
    return $clog2(n_samples);
  endfunction

  // Caller passes the sample zero-padded to EXT_MAX_W and truncates the
  // result to its own sum width.
  function automatic logic [EXT_MAX_W-1:0] sext_zext(
    input logic [EXT_MAX_W-1:0] data,
    input int                   data_w,
    input bit                   is_signed
  );
    logic [EXT_MAX_W-1:0] upper_mask;
    logic [5:0]           msb;
    upper_mask = {EXT_MAX_W{1'b1}} << data_w;
    msb        = 6'(data_w - 1);
    return (data & ~upper_mask) | ((is_signed && data[msb]) ? upper_mask : '0);
  endfunction

endpackage

// File: rtl/accum_nsample_if.sv
// Sample-in / block-sum-out handshake bundle for accum_nsample.
interface accum_nsample_if
  import accum_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int N_SAMPLES = 4
);
  localparam int SUM_W = sum_width(DATA_W, N_SAMPLES);
  localparam int CNT_W = cnt_width(N_SAMPLES);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data;
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  sum;
  logic [CNT_W-1:0]  count;

  modport master (
    output in_valid, data, out_ready,
    input  in_ready, out_valid, sum, count
  );

  modport slave (
    input  in_valid, data, out_ready,
    output in_ready, out_valid, sum, count
  );
endinterface

// File: rtl/accum_nsample.sv
// N-sample block accumulator: sums N_SAMPLES accepted samples and holds the
// block sum under a ready/valid handshake, with zero-bubble block chaining.
module accum_nsample
  import accum_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int N_SAMPLES = 4,
  parameter int SIGNED    = 0,
  parameter int SUM_W     = sum_width(DATA_W, N_SAMPLES),
  parameter int CNT_W     = cnt_width(N_SAMPLES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  accum_nsample_if.slave    bus
);

  state_t           state_reg, state_next;
  logic [SUM_W-1:0] sum_reg, sum_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [SUM_W-1:0] ext_data;
  logic             in_ready_c;
  logic             last_sample;

  assign ext_data    = SUM_W'(sext_zext(EXT_MAX_W'(bus.data), DATA_W, SIGNED != 0));
  assign last_sample = (count_reg == CNT_W'(N_SAMPLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ACCUM;
      sum_reg   <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      sum_reg   <= sum_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sum_next   = sum_reg;
    count_next = count_reg;
    in_ready_c = 1'b1;

    case (state_reg)
      ACCUM: begin
        in_ready_c = 1'b1;
        // Abort beats a sample arriving in the same cycle.
        if (clear) begin
          sum_next   = '0;
          count_next = '0;
        end else if (bus.in_valid) begin
          sum_next = (count_reg == '0) ? ext_data : sum_reg + ext_data;
          if (last_sample) begin
            count_next = '0;
            state_next = HOLD;
          end else begin
            count_next = count_reg + CNT_W'(1);
          end
        end
      end

      HOLD: begin
        // Result is frozen until consumed; clear cannot discard it.
        in_ready_c = bus.out_ready;
        if (bus.out_ready) begin
          state_next = ACCUM;
          if (bus.in_valid) begin
            sum_next   = ext_data;
            count_next = CNT_W'(1);
          end
        end
      end

      default: begin
        state_next = ACCUM;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_reg == HOLD);
  assign bus.sum       = sum_reg;
  assign bus.count     = count_reg;

endmodule

// File: tb/tb_accum_nsample.sv
// Self-checking bench for accum_nsample: directed vector table, hand-written
// signed and back-to-back sequences, then randomized traffic against a model.
module tb_accum_nsample;

  localparam int N = 4;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       in_valid;
  logic [3:0] data;
  logic       out_ready;

  int n_err;
  int n_checks;

  accum_nsample_if #(.DATA_W(4), .N_SAMPLES(N)) bu ();
  accum_nsample_if #(.DATA_W(4), .N_SAMPLES(N)) bs ();

  assign bu.in_valid  = in_valid;
  assign bu.data      = data;
  assign bu.out_ready = out_ready;
  assign bs.in_valid  = in_valid;
  assign bs.data      = data;
  assign bs.out_ready = out_ready;

  accum_nsample #(.DATA_W(4), .N_SAMPLES(N), .SIGNED(0)) u_dut_u (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bu.slave)
  );

  accum_nsample #(.DATA_W(4), .N_SAMPLES(N), .SIGNED(1)) u_dut_s (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bs.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit rst;
    bit clr;
    bit iv;
    int d;
    bit ordy;
    bit eov;
    int esum;
    int ecnt;
    bit eir;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input bit rst, input bit clr, input bit iv, input int d, input bit ordy,
                     input bit eov, input int esum, input int ecnt, input bit eir);
    vec_t v;
    v.rst = rst; v.clr = clr; v.iv = iv; v.d = d; v.ordy = ordy;
    v.eov = eov; v.esum = esum; v.ecnt = ecnt; v.eir = eir;
    vecs.push_back(v);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; data = 4'd0; out_ready = 1'b0;
    next_cycle();
    reset = 1'b0;
  endtask

  function automatic int sx(input logic [3:0] d);
    return d[3] ? int'(d) - 16 : int'(d);
  endfunction

  // Reference model: the current block is a list of accepted samples; the
  // visible sum is whatever was last written (recomputed from the list).
  int  blk[$];
  bit  m_hold;
  int  m_usum;
  int  m_ssum;

  function automatic void m_refresh();
    int su, ss;
    su = 0; ss = 0;
    foreach (blk[k]) begin
      su += blk[k];
      ss += sx(4'(blk[k]));
    end
    m_usum = su & 63;
    m_ssum = ss & 63;
  endfunction

  function automatic void m_edge(input bit rst, input bit clr, input bit iv, input int d, input bit ordy);
    if (rst) begin
      blk.delete(); m_hold = 0; m_usum = 0; m_ssum = 0;
    end else if (m_hold) begin
      if (ordy) begin
        m_hold = 0;
        if (iv) begin
          blk.delete(); blk.push_back(d); m_refresh();
        end
      end
    end else if (clr) begin
      blk.delete(); m_usum = 0; m_ssum = 0;
    end else if (iv) begin
      blk.push_back(d);
      m_refresh();
      if (blk.size() == N) begin
        blk.delete();
        m_hold = 1;
      end
    end
  endfunction

  int  sd[9];
  int  sexp[9];
  bit  sov[9];
  int  results;
  bit  ready_dropped;

  initial begin
    n_err = 0;
    n_checks = 0;
    do_reset();
    do_reset();

    // Reset state, 1..4, two back-to-back 15x4 blocks
    add(0,0,1, 1,1, 0, 0,0,1);
    add(0,0,1, 2,1, 0, 1,1,1);
    add(0,0,1, 3,1, 0, 3,2,1);
    add(0,0,1, 4,1, 0, 6,3,1);
    add(0,0,0, 0,1, 1,10,0,1);
    add(0,0,0, 0,1, 0,10,0,1);
    add(0,0,1,15,1, 0,10,0,1);
    add(0,0,1,15,1, 0,15,1,1);
    add(0,0,1,15,1, 0,30,2,1);
    add(0,0,1,15,1, 0,45,3,1);
    add(0,0,1,15,1, 1,60,0,1);
    add(0,0,1,15,1, 0,15,1,1);
    add(0,0,1,15,1, 0,30,2,1);
    add(0,0,1,15,1, 0,45,3,1);
    add(0,0,0, 0,1, 1,60,0,1);
    add(0,0,0, 0,1, 0,60,0,1);
    // Gapped input: valid on cycles 0,3,4,9
    add(0,0,1, 2,1, 0,60,0,1);
    add(0,0,0, 0,1, 0, 2,1,1);
    add(0,0,0, 0,1, 0, 2,1,1);
    add(0,0,1, 2,1, 0, 2,1,1);
    add(0,0,1, 2,1, 0, 4,2,1);
    add(0,0,0, 0,1, 0, 6,3,1);
    add(0,0,0, 0,1, 0, 6,3,1);
    add(0,0,0, 0,1, 0, 6,3,1);
    add(0,0,0, 0,1, 0, 6,3,1);
    add(0,0,1, 2,1, 0, 6,3,1);
    add(0,0,0, 0,1, 1, 8,0,1);
    // Backpressure: 5x4 then 5 cycles of out_ready=0 with data 7 waiting
    add(0,0,1, 5,1, 0, 8,0,1);
    add(0,0,1, 5,1, 0, 5,1,1);
    add(0,0,1, 5,1, 0,10,2,1);
    add(0,0,1, 5,1, 0,15,3,1);
    for (int i = 0; i < 5; i++) add(0,0,1, 7,0, 1,20,0,0);
    add(0,0,1, 7,1, 1,20,0,1);
    add(0,0,0, 0,1, 0, 7,1,1);
    // Abort by clear, then by reset after 3,3
    add(0,1,0, 0,1, 0, 7,1,1);
    add(0,0,1, 3,1, 0, 0,0,1);
    add(0,0,1, 3,1, 0, 3,1,1);
    add(1,0,0, 0,1, 0, 6,2,1);
    add(0,0,0, 0,1, 0, 0,0,1);
    // Clear with a simultaneous sample 9, then 1x4, then clear during HOLD
    add(0,0,1, 3,1, 0, 0,0,1);
    add(0,0,1, 3,1, 0, 3,1,1);
    add(0,1,1, 9,1, 0, 6,2,1);
    add(0,0,1, 1,1, 0, 0,0,1);
    add(0,0,1, 1,1, 0, 1,1,1);
    add(0,0,1, 1,1, 0, 2,2,1);
    add(0,0,1, 1,1, 0, 3,3,1);
    add(0,0,0, 0,0, 1, 4,0,0);
    add(0,1,0, 0,0, 1, 4,0,0);
    add(0,0,0, 0,1, 1, 4,0,1);
    add(0,0,0, 0,1, 0, 4,0,1);

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; clear = vecs[i].clr; in_valid = vecs[i].iv;
      data = 4'(vecs[i].d); out_ready = vecs[i].ordy;
      @(negedge clk);
      $display("vec %0d: ov=%0d sum=%0d count=%0d in_ready=%0d", i,
               bu.out_valid, bu.sum, bu.count, bu.in_ready);
      check($sformatf("vec%0d out_valid", i), int'(bu.out_valid), int'(vecs[i].eov));
      check($sformatf("vec%0d sum", i),       int'(bu.sum),       vecs[i].esum);
      check($sformatf("vec%0d count", i),     int'(bu.count),     vecs[i].ecnt);
      check($sformatf("vec%0d in_ready", i),  int'(bu.in_ready),  int'(vecs[i].eir));
      next_cycle();
    end

    // Signed: -8 x4 -> -32, then 7,-1,-8,2 chained -> 0
    sd   = '{8, 8, 8, 8, 7, 15, 8, 2, 0};
    sexp = '{0, 56, 48, 40, 32, 7, 6, 62, 0};
    sov  = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      in_valid = (i < 8); data = 4'(sd[i]); out_ready = 1'b1;
      @(negedge clk);
      $display("signed step %0d: ov=%0d sum=%0d", i, bs.out_valid, bs.sum);
      check($sformatf("signed sum step%0d", i), int'(bs.sum), sexp[i]);
      check($sformatf("signed out_valid step%0d", i), int'(bs.out_valid), int'(sov[i]));
      next_cycle();
    end
    check("unsigned view of 7,15,8,2", int'(bu.sum), 32);

    // Eight back-to-back 15x4 blocks: no bubbles, eight results of 60
    do_reset();
    results = 0;
    ready_dropped = 0;
    for (int i = 0; i < 33; i++) begin
      in_valid = (i < 32); data = 4'd15; out_ready = 1'b1;
      @(negedge clk);
      if (!bu.in_ready) ready_dropped = 1;
      if (bu.out_valid) begin
        results++;
        $display("b2b result %0d: sum=%0d", results, bu.sum);
        check($sformatf("b2b sum %0d", results), int'(bu.sum), 60);
      end
      next_cycle();
    end
    check("b2b result count", results, 8);
    check("b2b in_ready drops", int'(ready_dropped), 0);

    // Randomized traffic against the reference model
    do_reset();
    blk.delete(); m_hold = 0; m_usum = 0; m_ssum = 0;
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 63) == 0);
      clear     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      data      = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      check("rnd out_valid",   int'(bu.out_valid), int'(m_hold));
      check("rnd in_ready",    int'(bu.in_ready),  int'(!m_hold || out_ready));
      check("rnd count",       int'(bu.count),     blk.size());
      check("rnd sum",         int'(bu.sum),       m_usum);
      check("rnd s.out_valid", int'(bs.out_valid), int'(m_hold));
      check("rnd s.count",     int'(bs.count),     blk.size());
      check("rnd s.sum",       int'(bs.sum),       m_ssum);
      if (m_hold && out_ready && !reset)
        $display("rnd cycle %0d: block consumed usum=%0d ssum=%0d", i, bu.sum, bs.sum);
      m_edge(reset, clear, in_valid, int'(data), out_ready);
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/accum_nsample.md
Name: accum_nsample

Overview:
- Parametrised N-sample block accumulator; generalises the fixed 4-cycle adder.
- Sums N_SAMPLES valid-qualified input words into one result and presents it with a ready/valid output handshake.
- Supports signed or unsigned data.
- Sits between a sample source (ADC front end or filter stage) and a consumer that reads block sums.

Parameters:
DATA_W, 4, input sample width in bits
N_SAMPLES, 4, samples per block; legal range is 2 or more
SIGNED, 0, 0 = unsigned samples, 1 = two's-complement samples
SUM_W, DATA_W + $clog2(N_SAMPLES), result width; derived, do not override
CNT_W, $clog2(N_SAMPLES), sample index width; derived

Ports:
clk  input  1  clock, rising-edge
reset  input  1  synchronous, active-high reset
clear  input  1  synchronous abort of the partial block; lower priority than reset
in_valid  input  1  data is valid this cycle
in_ready  output  1  block accepts a sample this cycle
data  input  DATA_W  sample
out_valid  output  1  sum holds a completed block result
out_ready  input  1  consumer accepts the result
sum  output  SUM_W  running or completed block sum
count  output  CNT_W  number of samples accepted in the current block

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk. All state changes occur on the rising edge of clk.
- Reset values:
  - sum = 0, count = 0, out_valid = 0, state = ACCUM.
  - in_ready = 1 in the first cycle after reset.
- Accept: a sample is accepted when in_valid && in_ready.
- Extension: data is extended to SUM_W bits before adding.
  - SIGNED=0: zero-extend.
  - SIGNED=1: sign-extend.
- Overflow: SUM_W guarantees no overflow for N_SAMPLES worst-case samples. Arithmetic is modulo 2^SUM_W.
- State ACCUM:
  - in_ready = 1.
  - First accepted sample (count==0): sum <= ext(data), count <= 1.
  - Each later accepted sample: sum <= sum + ext(data), count <= count + 1.
  - On acceptance of sample number N_SAMPLES: sum <= final value, count <= 0, out_valid <= 1, go to HOLD.
  - Latency: out_valid asserts the cycle after the last sample is accepted.
  - Cycles with in_valid=0 leave sum and count unchanged; gaps are allowed.
- State HOLD:
  - sum is frozen and out_valid = 1.
  - in_ready = out_ready, a combinational pass-through.
  - out_ready=1 and in_valid=0: out_valid <= 0, go to ACCUM, sum unchanged.
  - out_ready=1 and in_valid=1: the result is consumed and data is taken as sample 1 of the next block in the same edge. sum <= ext(data), count <= 1, out_valid <= 0, go to ACCUM. Zero-bubble back-to-back operation.
  - out_ready=0: in_ready = 0, and no sample is lost.
- clear (and not reset):
  - count <= 0 and sum <= 0.
  - In ACCUM: the partial block is discarded. A sample presented in the same cycle is dropped; in_ready stays 1, but clear wins.
  - In HOLD: clear has no effect. A completed result is never discarded except by reset.
- reset mid-block or in HOLD: everything returns to reset values the next cycle. The partial result is lost and no out_valid is produced.
- sum is observable during ACCUM as the partial sum. It is meaningful to the consumer only when out_valid=1.

Decomposition:
- Shared package accum_pkg:
  - State enum {ACCUM, HOLD}.
  - Function sext_zext(data, SIGNED) returning SUM_W bits.
  - Localparam helper for SUM_W.
- Single module. No sub-module is warranted; the datapath is one adder plus a counter.

Test Plan:
- Default params; in_valid=1 with data 1,2,3,4 and out_ready=1 -> out_valid for 1 cycle, sum=10 (6'd10), in_ready never drops.
- Default params; four samples of 15 -> sum=60 (6'b111100), no overflow. Repeat back-to-back with 8 blocks -> 8 results, zero bubbles.
- Gapped input: valid on cycles 0,3,4,9 with data 2,2,2,2 -> out_valid the cycle after cycle 9, sum=8; count steps 1,2,3,0.
- Backpressure: block 5,5,5,5, then hold out_ready=0 for 5 cycles with in_valid=1 data 7 -> sum stays 20, in_ready=0, no sample consumed. When out_ready=1, 7 is loaded as sample 1 (count=1, sum=7).
- Abort: after samples 3,3 (count=2, sum=6) assert reset for 1 cycle -> sum=0, count=0, out_valid=0. Repeat with clear and a simultaneous data=9 sample -> 9 is dropped. Next block 1,1,1,1 -> sum=4.
- SIGNED=1, DATA_W=4: samples -8,-8,-8,-8 -> sum=-32 (6'b100000). Samples 7,-1,-8,2 -> sum=0.
